// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg
// Shared constants and state encodings for the CarbonZ480 sim-control port:
//   - register offsets inside the sigport window
//   - default base port and power-off arming key
//   - bus handshake and power-off key FSM state enums
package carbon_arch_pkg;

  localparam logic [7:0] CARBON_SIGPORT_BASE     = 8'hF0;
  localparam logic [7:0] CARBON_SIGPORT_KEY      = 8'hA5;

  localparam logic [1:0] CARBON_SIGPORT_OFF_DATA = 2'd0;
  localparam logic [1:0] CARBON_SIGPORT_OFF_CTRL = 2'd1;
  localparam logic [1:0] CARBON_SIGPORT_OFF_PWR  = 2'd2;
  localparam logic [1:0] CARBON_SIGPORT_OFF_STAT = 2'd3;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_RESP = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    KEY_DISARMED = 2'd0,
    KEY_ARMED    = 2'd1,
    KEY_OFF      = 2'd2
  } key_state_e;

endpackage

// File: rtl/carbon_sigport_keyfsm.sv
// carbon_sigport_keyfsm
// Keyed two-write power-off sequencer.
//   state    | meaning
//   DISARMED | waiting for the arming key
//   ARMED    | key seen; next write of 8'h00 powers off, anything else disarms
//   OFF      | power-off requested; terminal until reset
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wr_stb       one-cycle strobe: committed write to the POWEROFF register
//   wr_data      data of that write
//   armed        state is ARMED
//   poweroff     state is OFF (sticky)
module carbon_sigport_keyfsm
  import carbon_arch_pkg::*;
#(
  parameter logic [7:0] POWEROFF_KEY = CARBON_SIGPORT_KEY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  output logic       armed,
  output logic       poweroff
);

  key_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= KEY_DISARMED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_stb) begin
      case (state)
        KEY_DISARMED: if (wr_data == POWEROFF_KEY) state_nxt = KEY_ARMED;
        KEY_ARMED:    state_nxt = (wr_data == 8'h00) ? KEY_OFF : KEY_DISARMED;
        KEY_OFF:      state_nxt = KEY_OFF;
        default:      state_nxt = KEY_DISARMED;
      endcase
    end
  end

  always_comb begin
    armed    = (state == KEY_ARMED);
    poweroff = (state == KEY_OFF);
  end

endmodule

// File: rtl/carbonz480_sigport.sv
// carbonz480_sigport
// Simulation-control I/O peripheral: ASCII signature accumulator plus a keyed
// power-off request, behind a fixed-latency valid/ready bus slave.
//   state | meaning
//   IDLE  | ready for a request; accepts in-window requests
//   WAIT  | wait states, counted down from WAIT_CYCLES-1
//   RESP  | rsp_valid pulse; register side effects committed on entry
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready            request handshake (ready only in IDLE)
//   req_write/addr/wdata       request command
//   hit                        combinational: req_addr inside the 4-port window
//   rsp_valid/rsp_rdata        one-cycle completion pulse and read data
//   signature, poweroff        system outputs
// Build option CARBON_SIGPORT_READBACK_EN: when defined, reads return register
// contents; otherwise every read returns 8'hFF.
module carbonz480_sigport
  import carbon_arch_pkg::*;
#(
  parameter logic [7:0]  BASE_PORT    = CARBON_SIGPORT_BASE,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter logic [7:0]  POWEROFF_KEY = CARBON_SIGPORT_KEY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        hit,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [31:0] signature,
  output logic        poweroff
);

  bus_state_e bus_state, bus_nxt;
  logic [7:0] req_delta;
  logic [1:0] req_off;
  logic [3:0] wait_cnt;
  logic       accept, commit;
  logic       lat_write, cmd_write;
  logic [1:0] lat_off, cmd_off;
  logic [7:0] lat_wdata, cmd_wdata;
  logic [1:0] idx;
  logic       armed;
  logic       key_stb;
  logic [7:0] rd_data;

  assign req_delta = req_addr - BASE_PORT;
  assign hit       = (req_addr >= BASE_PORT) && (req_delta[7:2] == 6'd0);
  assign req_off   = req_delta[1:0];
  assign accept    = req_valid && req_ready && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_state <= BUS_IDLE;
    else        bus_state <= bus_nxt;
  end

  always_comb begin
    bus_nxt = bus_state;
    case (bus_state)
      BUS_IDLE: if (accept) bus_nxt = (WAIT_CYCLES == 0) ? BUS_RESP : BUS_WAIT;
      BUS_WAIT: if (wait_cnt == 4'd0) bus_nxt = BUS_RESP;
      BUS_RESP: bus_nxt = BUS_IDLE;
      default:  bus_nxt = BUS_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (bus_state == BUS_IDLE);
    rsp_valid = (bus_state == BUS_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_off   <= 2'd0;
      lat_wdata <= 8'h00;
    end else if (accept) begin
      wait_cnt  <= 4'(WAIT_CYCLES - 1);
      lat_write <= req_write;
      lat_off   <= req_off;
      lat_wdata <= req_wdata;
    end else if (bus_state == BUS_WAIT && wait_cnt != 4'd0) begin
      wait_cnt  <= wait_cnt - 4'd1;
    end
  end

  // Side effects commit on the edge entering RESP. With no wait states that
  // edge is also the accept edge, so the command comes straight off the bus.
  assign commit    = (bus_nxt == BUS_RESP) && (bus_state != BUS_RESP);
  assign cmd_write = (bus_state == BUS_IDLE) ? req_write : lat_write;
  assign cmd_off   = (bus_state == BUS_IDLE) ? req_off   : lat_off;
  assign cmd_wdata = (bus_state == BUS_IDLE) ? req_wdata : lat_wdata;

`ifdef CARBON_SIGPORT_READBACK_EN
  always_comb begin
    rd_data = 8'h00;
    case (cmd_off)
      CARBON_SIGPORT_OFF_DATA: rd_data = signature[{idx, 3'b000} +: 8];
      CARBON_SIGPORT_OFF_STAT: rd_data = {4'b0000, idx, armed, poweroff};
      default:                 rd_data = 8'h00;
    endcase
  end
`else
  logic armed_unused;
  assign armed_unused = armed;
  assign rd_data      = 8'hFF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= 32'h0;
      idx       <= 2'd0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_rdata <= 8'h00;
      if (commit) begin
        if (!cmd_write) begin
          rsp_rdata <= rd_data;
        end else if (!poweroff) begin
          case (cmd_off)
            CARBON_SIGPORT_OFF_DATA: begin
              signature[{idx, 3'b000} +: 8] <= cmd_wdata;
              idx <= idx + 2'd1;
            end
            CARBON_SIGPORT_OFF_CTRL: begin
              if (cmd_wdata[0]) begin
                signature <= 32'h0;
                idx       <= 2'd0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign key_stb = commit && cmd_write && (cmd_off == CARBON_SIGPORT_OFF_PWR);

  carbon_sigport_keyfsm #(
    .POWEROFF_KEY (POWEROFF_KEY)
  ) u_keyfsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_stb   (key_stb),
    .wr_data  (cmd_wdata),
    .armed    (armed),
    .poweroff (poweroff)
  );

endmodule

// File: tb/tb_carbonz480_sigport.sv
module tb_carbonz480_sigport;
  import carbon_arch_pkg::*;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [31:0] exp_sig;
    bit         exp_poff;
    logic [7:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic req_valid = 1'b0;
  logic req_valid0 = 1'b0;

  logic req_ready, hit, rsp_valid, poweroff;
  logic [7:0] rsp_rdata;
  logic [31:0] signature;
  logic req_ready0, hit0, rsp_valid0, poweroff0;
  logic [7:0] rsp_rdata0;
  logic [31:0] signature0;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  carbonz480_sigport #(.BASE_PORT(8'hF0), .WAIT_CYCLES(1), .POWEROFF_KEY(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .hit(hit),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .signature(signature), .poweroff(poweroff));

  carbonz480_sigport #(.BASE_PORT(8'hF0), .WAIT_CYCLES(0), .POWEROFF_KEY(8'hA5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .hit(hit0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .signature(signature0), .poweroff(poweroff0));

  function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef CARBON_SIGPORT_READBACK_EN
    return v;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [31:0] sig, input bit poff, input logic [7:0] rd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_sig = sig; v.exp_poff = poff; v.exp_rd = rd;
    vecs.push_back(v);
  endtask

  // One bus transaction; returns read data and the number of negedges from
  // the accept edge to the one where rsp_valid is seen (-1 if never).
  task automatic xfer(input bit d0, input bit wr, input logic [7:0] addr,
                      input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    lat = -1;
    rdata = 8'hXX;
    @(negedge clk);
    for (int w = 0; w < 10; w++) begin
      if (d0 ? req_ready0 : req_ready) break;
      @(negedge clk);
    end
    req_write = wr; req_addr = addr; req_wdata = wdata;
    if (d0) req_valid0 = 1'b1; else req_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_valid0 = 1'b0;
      if (d0 ? rsp_valid0 : rsp_valid) begin
        lat = k;
        rdata = d0 ? rsp_rdata0 : rsp_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int lat;
    int cnt_hit, cnt_rsp, cnt_nr;

    //   wr addr   wdata  exp_sig        poff exp_rdata
    add(1, 8'hF0, 8'h5A, 32'h0000_005A, 0, 8'h00);
    add(1, 8'hF0, 8'h34, 32'h0000_345A, 0, 8'h00);
    add(1, 8'hF0, 8'h38, 32'h0038_345A, 0, 8'h00);
    add(1, 8'hF0, 8'h30, 32'h3038_345A, 0, 8'h00);
    add(0, 8'hF3, 8'h00, 32'h3038_345A, 0, rb(8'h00));
    add(0, 8'hF0, 8'h00, 32'h3038_345A, 0, rb(8'h5A));
    add(1, 8'hF0, 8'h11, 32'h3038_3411, 0, 8'h00);
    add(1, 8'hF0, 8'h22, 32'h3038_2211, 0, 8'h00);
    add(1, 8'hF0, 8'h33, 32'h3033_2211, 0, 8'h00);
    add(1, 8'hF0, 8'h44, 32'h4433_2211, 0, 8'h00);
    add(1, 8'hF0, 8'h55, 32'h4433_2255, 0, 8'h00);
    add(0, 8'hF3, 8'h00, 32'h4433_2255, 0, rb(8'h04));
    add(0, 8'hF1, 8'h00, 32'h4433_2255, 0, rb(8'h00));
    add(1, 8'hF1, 8'hFE, 32'h4433_2255, 0, 8'h00);
    add(1, 8'hF1, 8'h01, 32'h0000_0000, 0, 8'h00);
    add(1, 8'hF2, 8'hA5, 32'h0000_0000, 0, 8'h00);
    add(0, 8'hF3, 8'h00, 32'h0000_0000, 0, rb(8'h02));
    add(1, 8'hF2, 8'h7F, 32'h0000_0000, 0, 8'h00);
    add(1, 8'hF2, 8'h00, 32'h0000_0000, 0, 8'h00);
    add(1, 8'hF2, 8'hA5, 32'h0000_0000, 0, 8'h00);
    add(1, 8'hF0, 8'h12, 32'h0000_0012, 0, 8'h00);
    add(1, 8'hF2, 8'h00, 32'h0000_0012, 1, 8'h00);
    add(1, 8'hF0, 8'hEE, 32'h0000_0012, 1, 8'h00);
    add(1, 8'hF1, 8'h01, 32'h0000_0012, 1, 8'h00);
    add(0, 8'hF3, 8'h00, 32'h0000_0012, 1, rb(8'h05));
    add(0, 8'hF0, 8'h00, 32'h0000_0012, 1, rb(8'h00));

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst signature", signature, 32'h0);
    chk("rst poweroff", 32'(poweroff), 32'd0);
    rst_n = 1'b1;

    // Window boundaries.
    req_addr = 8'hEF; #1 chk("hit EF", 32'(hit), 32'd0);
    req_addr = 8'hF0; #1 chk("hit F0", 32'(hit), 32'd1);
    req_addr = 8'hF3; #1 chk("hit F3", 32'(hit), 32'd1);
    req_addr = 8'hF4; #1 chk("hit F4", 32'(hit), 32'd0);

    // Out-of-window request held for 10 cycles.
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h99; req_valid = 1'b1;
    cnt_hit = 0; cnt_rsp = 0; cnt_nr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hit) cnt_hit++;
      if (rsp_valid) cnt_rsp++;
      if (!req_ready) cnt_nr++;
    end
    req_valid = 1'b0;
    chk("oow hit cycles", 32'(cnt_hit), 32'd0);
    chk("oow rsp cycles", 32'(cnt_rsp), 32'd0);
    chk("oow busy cycles", 32'(cnt_nr), 32'd0);
    chk("oow signature", signature, 32'h0);

    // Main table.
    foreach (vecs[i]) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("row%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("row%0d signature", i), signature, vecs[i].exp_sig);
      chk($sformatf("row%0d poweroff", i), 32'(poweroff), 32'(vecs[i].exp_poff));
      chk($sformatf("row%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Reset asserted during WAIT.
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'hF0; req_wdata = 8'hAB; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst in wait", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("midrst signature", signature, 32'h0);
    chk("midrst poweroff", 32'(poweroff), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt_rsp++;
    end
    chk("midrst no response", 32'(cnt_rsp), 32'd0);
    chk("midrst sig after", signature, 32'h0);

    // Key FSM after reset: 00 alone, and key-key-00, must not power off.
    xfer(1'b0, 1'b1, 8'hF2, 8'h00, rd, lat);
    chk("key 00 disarmed", 32'(poweroff), 32'd0);
    xfer(1'b0, 1'b1, 8'hF2, 8'hA5, rd, lat);
    xfer(1'b0, 1'b1, 8'hF2, 8'hA5, rd, lat);
    xfer(1'b0, 1'b1, 8'hF2, 8'h00, rd, lat);
    chk("key A5 A5 00", 32'(poweroff), 32'd0);
    xfer(1'b0, 1'b1, 8'hF2, 8'hA5, rd, lat);
    xfer(1'b0, 1'b1, 8'hF2, 8'h00, rd, lat);
    chk("key A5 00", 32'(poweroff), 32'd1);

    // Zero wait states.
    xfer(1'b1, 1'b1, 8'hF0, 8'h77, rd, lat);
    chk("w0 write latency", 32'(lat), 32'd1);
    chk("w0 signature", signature0, 32'h0000_0077);
    chk("w0 write rdata", 32'(rd), 32'h0);
    xfer(1'b1, 1'b0, 8'hF3, 8'h00, rd, lat);
    chk("w0 read latency", 32'(lat), 32'd1);
    chk("w0 status", 32'(rd), 32'(rb(8'h04)));
    chk("w0 main untouched", signature, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
